// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Per-bit debounce filter, edge pulses, sticky pending flags and interrupt
// request for already-synchronized GPIO pin levels.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   SyncIn        synchronized pin levels
//   DebounceEn    1 = filter active, 0 = one-cycle registered pass-through
//   DebounceLimit extra consecutive cycles a new level must persist
//   RiseIE/FallIE per-bit interrupt enables
//   PendClr       write-1-to-clear strobe for both pending flags of a bit
//   Filtered      debounced level
//   RisePulse     one-cycle pulse on Filtered 0->1
//   FallPulse     one-cycle pulse on Filtered 1->0
//   RisePending   sticky rise flag
//   FallPending   sticky fall flag
//   Irq           OR of enabled pending flags
module gpio_input_conditioner #(
    parameter int          N    = 32,
    parameter int          CW   = 16,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  SyncIn,
    input  logic          DebounceEn,
    input  logic [CW-1:0] DebounceLimit,
    input  logic [N-1:0]  RiseIE,
    input  logic [N-1:0]  FallIE,
    input  logic [N-1:0]  PendClr,
    output logic [N-1:0]  Filtered,
    output logic [N-1:0]  RisePulse,
    output logic [N-1:0]  FallPulse,
    output logic [N-1:0]  RisePending,
    output logic [N-1:0]  FallPending,
    output logic          Irq
);

    logic [CW-1:0] r_cnt      [N];
    logic [CW-1:0] w_cnt_next [N];
    logic [N-1:0]  w_f_next;
    logic [N-1:0]  w_rise;
    logic [N-1:0]  w_fall;

    // Counter holds the number of differing samples already seen; the
    // sample that finds it at or above the limit is the accepting one.
    // Using >= also covers the limit being lowered below a running count.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_f_next[i]   = Filtered[i];
            w_cnt_next[i] = '0;
            if (!DebounceEn) begin
                w_f_next[i] = SyncIn[i];
            end else if (SyncIn[i] != Filtered[i]) begin
                if (r_cnt[i] >= DebounceLimit) begin
                    w_f_next[i] = SyncIn[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise = w_f_next & ~Filtered;
    assign w_fall = ~w_f_next & Filtered;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Filtered    <= INIT;
            RisePulse   <= '0;
            FallPulse   <= '0;
            RisePending <= '0;
            FallPending <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            Filtered    <= w_f_next;
            RisePulse   <= w_rise;
            FallPulse   <= w_fall;
            // A new event on the clearing edge keeps the flag set.
            RisePending <= (RisePending & ~PendClr) | w_rise;
            FallPending <= (FallPending & ~PendClr) | w_fall;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign Irq = |((RisePending & RiseIE) | (FallPending & FallIE));

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Per-bit input conditioner that sits directly downstream of the two-stage synchronizers on GPIO pins.
- Consumes already-synchronized pin levels and produces:
  - debounced (filtered) levels
  - single-cycle rise/fall pulses
  - sticky rise/fall pending flags
  - a combined interrupt request for the GPIO register block and PLIC.
- Entirely in the synchronized clock domain. Performs no synchronization itself.

Parameters:
- N, 32, number of independent input bits.
- CW, 16, width of the debounce counter and of DebounceLimit.
- INIT, 0, N-bit reset value of Filtered (per bit).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- SyncIn  input  N  synchronized pin levels (q outputs of the synchronizers).
- DebounceEn  input  1  1 = debounce filtering active; 0 = pass-through with 1-cycle register.
- DebounceLimit  input  CW  extra consecutive cycles a new level must persist before acceptance.
- RiseIE  input  N  rise interrupt enable per bit.
- FallIE  input  N  fall interrupt enable per bit.
- PendClr  input  N  write-1-to-clear strobe for both pending flags of each bit.
- Filtered  output  N  debounced level, registered.
- RisePulse  output  N  one-cycle pulse when Filtered goes 0->1, registered.
- FallPulse  output  N  one-cycle pulse when Filtered goes 1->0, registered.
- RisePending  output  N  sticky rise flag.
- FallPending  output  N  sticky fall flag.
- Irq  output  1  OR of enabled pending flags.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - While reset is asserted: Filtered=INIT, all counters=0, RisePulse=FallPulse=0, RisePending=FallPending=0, Irq=0.
  - Reset asserted mid-count discards partial counts. No pulses are generated by reset release.
- Per-bit filter, with d = SyncIn[i], f = Filtered[i], c = counter[i] (CW bits):
  - DebounceEn=0: f <= d every cycle, c <= 0. Latency is 1 cycle.
  - DebounceEn=1 and d==f: c <= 0. Any glitch back to the stable level restarts the count.
  - DebounceEn=1 and d!=f and c >= DebounceLimit: f <= d, c <= 0.
  - DebounceEn=1 and d!=f and c < DebounceLimit: c <= c+1.
- Acceptance timing:
  - A new level is accepted after DebounceLimit+1 consecutive differing samples.
  - Filtered updates on the edge that samples the (DebounceLimit+1)-th differing value.
  - DebounceLimit=0 therefore behaves identically to DebounceEn=0.
- Counter bounds:
  - The counter never exceeds DebounceLimit, so there is no wrap.
  - If DebounceLimit is lowered below the current count, the >= compare accepts on the next differing sample.
- Toggling DebounceEn:
  - Takes effect on the next edge.
  - 1->0 clears counters and passes the input through.
  - 0->1 starts counting from 0.
- Pulses:
  - RisePulse[i] <= (next f == 1) && (f == 0); FallPulse[i] <= (next f == 0) && (f == 1).
  - Each pulse is asserted in the same cycle Filtered first shows the new value, for exactly one cycle.
  - Rise and fall are never simultaneous on the same bit.
- Pending flags:
  - RisePending[i] <= (RisePending[i] & ~PendClr[i]) | rise_event[i], where rise_event is the registered-pulse condition.
  - FallPending uses the same rule with the fall event.
  - Set wins over clear on the same edge.
  - Pending flags are set regardless of RiseIE/FallIE.
- Irq:
  - Irq = |((RisePending & RiseIE) | (FallPending & FallIE)).
  - Combinational from registers and enables; no added latency, glitch-free with respect to SyncIn.
- Bits are fully independent. No shared counter.

Test Plan:
1. Reset, then pass-through. Assert reset, then release with INIT=0, SyncIn=0, DebounceEn=0. Drive SyncIn[0] 0->1 at cycle 5 and 1->0 at cycle 9. Required: Filtered[0]=1 at cycles 6-9, RisePulse[0] high only at cycle 6, FallPulse[0] high only at cycle 10, RisePending[0] and FallPending[0] both set, Irq=0 with IEs=0.
2. Debounce accept. DebounceEn=1, DebounceLimit=3, SyncIn[3] held 1 from cycle 0. Required: Filtered[3] rises on the 4th edge (cycle 4) with a single RisePulse[3] at cycle 4.
3. Debounce reject glitch. DebounceLimit=3, SyncIn[3] is 1 for 3 cycles, 0 for 1 cycle, then 1 for 3 cycles. Required: Filtered[3] stays 0, no pulses, pending flags stay 0.
4. Pending, clear and interrupt. RiseIE[7]=1, produce a rise on bit 7. Required: Irq=1 in the pulse cycle. Then PendClr[7]=1 for one cycle: RisePending[7]=0 and Irq=0 on the next cycle. Repeat with PendClr[7] coincident with a new rise event: RisePending[7] stays 1.
5. Limit change mid-count. DebounceLimit=10, hold SyncIn[1] differing for 6 cycles, then set DebounceLimit=2. Required: acceptance on the next edge (counter 6 >= 2), one pulse only.
6. Reset mid-operation. Assert reset asynchronously between edges while counters are partial and pending flags are set. Required: all outputs return immediately to reset values (Filtered=INIT) and stay there until release. With SyncIn==INIT after release, no pulses are generated.
